// File: rtl/serialsniff_pkg.sv
// Shared types and constants for the register-bus UART sniffer.
package serialsniff_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [15:0] CFG_DIV_LO = 16'd0;
  localparam logic [15:0] CFG_DIV_HI = 16'd1;
  localparam logic [15:0] CFG_CTRL   = 16'd2;
  localparam logic [15:0] CFG_STATUS = 16'd3;
  localparam logic [15:0] CFG_MATCH  = 16'd4;

  localparam logic [15:0] DAT_COUNT = 16'd0;
  localparam logic [15:0] DAT_HEAD  = 16'd1;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_SRC      = 1;
  localparam int CTRL_FLUSH    = 2;
  localparam int CTRL_MATCH_EN = 3;

  localparam int STAT_EMPTY    = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_OVERFLOW = 2;
  localparam int STAT_FERR     = 3;

  localparam logic [15:0] HYPLEN_CFG  = 16'd5;
  localparam logic [15:0] HYPLEN_DATA = 16'd2;

  localparam logic [15:0] MIN_DIVISOR = 16'd4;

endpackage

// File: rtl/reg_serialsniff_uart_rx.sv
// 8N1 receiver: 2-flop synchronizer on the selected target line, then a
// mid-bit sampling FSM. Emits one-cycle data_valid / frame_err pulses.
module uart_rx_core
  import serialsniff_pkg::*;
(
  input  logic        clk,
  input  logic        reset_i,
  input  logic        rx_io1,
  input  logic        rx_io2,
  input  logic        src,
  input  logic        enable,
  input  logic [15:0] divisor,
  output logic        data_valid,
  output logic [7:0]  data,
  output logic        frame_err
);

  logic       sync_p0, sync_p1, sync_p2;
  rx_state_t  state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        line, fall, run_ok, sample;

  assign line   = sync_p1;
  assign fall   = sync_p2 & ~sync_p1;
  assign run_ok = enable && (divisor >= MIN_DIVISOR);
  assign sample = (cnt == 16'd0);
  assign data   = shreg;

  // Stage p0/p1: synchronizer; p2 holds the previous level for edge detect
  always_ff @(posedge clk) begin
    if (reset_i) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      sync_p2 <= 1'b1;
    end else begin
      sync_p0 <= src ? rx_io2 : rx_io1;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state      <= RX_IDLE;
      cnt        <= 16'd0;
      bit_idx    <= 3'd0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (!run_ok) begin
        state <= RX_IDLE;
      end else begin
        case (state)
          RX_IDLE: begin
            if (fall) begin
              state <= RX_START;
              cnt   <= divisor >> 1;
            end
          end
          RX_START: begin
            if (sample) begin
              if (!line) begin
                state   <= RX_DATA;
                cnt     <= divisor - 16'd1;
                bit_idx <= 3'd0;
              end else begin
                state <= RX_IDLE;
              end
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          RX_DATA: begin
            if (sample) begin
              cnt <= divisor - 16'd1;
              if (bit_idx == 3'd7) state <= RX_STOP;
              bit_idx <= bit_idx + 3'd1;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          RX_STOP: begin
            if (sample) begin
              data_valid <= line;
              frame_err  <= ~line;
              state      <= RX_IDLE;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

  // Data shift register, LSB arrives first
  always_ff @(posedge clk) begin
    if (run_ok && (state == RX_DATA) && sample) shreg <= {line, shreg[7:1]};
  end

endmodule

// File: rtl/reg_serialsniff.sv
// Register-bus UART sniffer: config/status registers, receive FIFO drained
// by the host, and a byte-match trigger pulse.
module reg_serialsniff
  import serialsniff_pkg::*;
#(
  parameter logic [5:0] CFG_ADDR   = 6'd52,
  parameter logic [5:0] DATA_ADDR  = 6'd53,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [5:0]  reg_address,
  input  logic [15:0] reg_bytecnt,
  input  logic [7:0]  reg_datai,
  output logic [7:0]  reg_datao,
  input  logic [15:0] reg_size,
  input  logic        reg_read,
  input  logic        reg_write,
  input  logic        reg_addrvalid,
  input  logic [5:0]  reg_hypaddress,
  output logic [15:0] reg_hyplen,
  output logic        reg_stream,
  input  logic        rx_io1,
  input  logic        rx_io2,
  output logic        trigger_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [15:0] divisor;
  logic        enable, src, match_en;
  logic [7:0]  match;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          overflow, ferr;

  logic       rx_valid, rx_ferr;
  logic [7:0] rx_data;
  logic       cfg_hit, dat_hit, cfg_wr, flush, empty, full, pop, push;
  logic       unused_reg_size;

  function automatic logic [7:0] sat_u8(input logic [AW:0] c);
    logic [31:0] w;
    w = 32'(c);
    return (w > 32'd255) ? 8'hFF : w[7:0];
  endfunction

  uart_rx_core u_rx (
    .clk        (clk),
    .reset_i    (reset_i),
    .rx_io1     (rx_io1),
    .rx_io2     (rx_io2),
    .src        (src),
    .enable     (enable),
    .divisor    (divisor),
    .data_valid (rx_valid),
    .data       (rx_data),
    .frame_err  (rx_ferr)
  );

  assign unused_reg_size = ^reg_size;
  assign reg_stream      = 1'b0;

  assign cfg_hit = reg_addrvalid && (reg_address == CFG_ADDR);
  assign dat_hit = reg_addrvalid && (reg_address == DATA_ADDR);
  assign cfg_wr  = reg_write && cfg_hit;
  assign flush   = cfg_wr && (reg_bytecnt == CFG_CTRL) && reg_datai[CTRL_FLUSH];
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = reg_read && dat_hit && (reg_bytecnt == DAT_HEAD) && !empty;
  // Pop frees a slot in the same cycle, so a full FIFO can still accept
  assign push    = rx_valid && !flush && (!full || pop);

  assign trigger_o = rx_valid && match_en && (rx_data == match);

  always_ff @(posedge clk) begin
    if (reset_i) begin
      divisor  <= 16'd0;
      enable   <= 1'b0;
      src      <= 1'b0;
      match_en <= 1'b0;
      match    <= 8'h00;
    end else if (cfg_wr) begin
      case (reg_bytecnt)
        CFG_DIV_LO: divisor[7:0]  <= reg_datai;
        CFG_DIV_HI: divisor[15:8] <= reg_datai;
        CFG_CTRL: begin
          enable   <= reg_datai[CTRL_ENABLE];
          src      <= reg_datai[CTRL_SRC];
          match_en <= reg_datai[CTRL_MATCH_EN];
        end
        CFG_MATCH: match <= reg_datai;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (!push && pop) count <= count - (AW+1)'(1);
      if (rx_valid && !push) overflow <= 1'b1;
      if (rx_ferr) ferr <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_comb begin
    reg_datao = 8'h00;
    if (cfg_hit) begin
      case (reg_bytecnt)
        CFG_DIV_LO: reg_datao = divisor[7:0];
        CFG_DIV_HI: reg_datao = divisor[15:8];
        CFG_CTRL:   reg_datao = {4'b0, match_en, 1'b0, src, enable};
        CFG_STATUS: reg_datao = {4'b0, ferr, overflow, full, empty};
        CFG_MATCH:  reg_datao = match;
        default:    reg_datao = 8'h00;
      endcase
    end else if (dat_hit) begin
      case (reg_bytecnt)
        DAT_COUNT: reg_datao = sat_u8(count);
        DAT_HEAD:  reg_datao = empty ? 8'h00 : mem[rd_ptr];
        default:   reg_datao = 8'h00;
      endcase
    end
  end

  always_comb begin
    reg_hyplen = 16'd0;
    if (reg_hypaddress == CFG_ADDR)       reg_hyplen = HYPLEN_CFG;
    else if (reg_hypaddress == DATA_ADDR) reg_hyplen = HYPLEN_DATA;
  end

endmodule

// File: tb/tb_reg_serialsniff.sv
// Bench for reg_serialsniff: directed scenarios plus randomized frames and
// pops checked against a queue-based model of the sniffer.
module tb_reg_serialsniff;

  localparam logic [5:0] CFG = 6'd52;
  localparam logic [5:0] DAT = 6'd53;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [5:0]  reg_address = '0;
  logic [15:0] reg_bytecnt = '0;
  logic [7:0]  reg_datai = '0;
  logic [7:0]  reg_datao;
  logic [15:0] reg_size = '0;
  logic        reg_read = 1'b0;
  logic        reg_write = 1'b0;
  logic        reg_addrvalid = 1'b0;
  logic [5:0]  reg_hypaddress = '0;
  logic [15:0] reg_hyplen;
  logic        reg_stream;
  logic        rx_io1 = 1'b1;
  logic        rx_io2 = 1'b1;
  logic        trigger_o;

  always #5 clk = ~clk;

  reg_serialsniff #(.CFG_ADDR(CFG), .DATA_ADDR(DAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_i(reset_i), .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
    .reg_datai(reg_datai), .reg_datao(reg_datao), .reg_size(reg_size), .reg_read(reg_read),
    .reg_write(reg_write), .reg_addrvalid(reg_addrvalid), .reg_hypaddress(reg_hypaddress),
    .reg_hyplen(reg_hyplen), .reg_stream(reg_stream), .rx_io1(rx_io1), .rx_io2(rx_io2),
    .trigger_o(trigger_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int trig_total = 0;
  int trig_last = 0;

  // Reference model state
  logic [7:0] byte_q[$];
  bit         m_ovf = 0, m_ferr = 0, m_src = 0, m_match_en = 0;
  logic [7:0] m_match = 8'h00;
  int         div = 16;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (trigger_o === 1'b1) begin
    trig_total <= trig_total + 1;
    trig_last  <= cyc;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [15:0] bc, input logic [7:0] d);
    @(negedge clk);
    reg_address = CFG; reg_bytecnt = bc; reg_datai = d;
    reg_addrvalid = 1'b1; reg_write = 1'b1;
    @(negedge clk);
    reg_write = 1'b0; reg_addrvalid = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [15:0] bc, input bit do_pop,
                    output logic [7:0] d);
    @(negedge clk);
    reg_address = a; reg_bytecnt = bc; reg_addrvalid = 1'b1; reg_read = do_pop;
    #1 d = reg_datao;
    @(negedge clk);
    reg_read = 1'b0; reg_addrvalid = 1'b0;
  endtask

  task automatic set_ctrl(input bit en, input bit s, input bit fl, input bit men);
    wr(16'd2, {4'b0, men, fl, s, en});
    m_src = s; m_match_en = men;
    if (fl) begin
      byte_q.delete(); m_ovf = 0; m_ferr = 0;
    end
  endtask

  task automatic set_match(input logic [7:0] b);
    wr(16'd4, b); m_match = b;
  endtask

  task automatic set_div(input int d);
    wr(16'd0, 8'(d)); wr(16'd1, 8'(d >> 8)); div = d;
  endtask

  task automatic drive_line(input logic v);
    if (m_src) rx_io2 = v; else rx_io1 = v;
  endtask

  task automatic send_raw(input logic [7:0] b, input bit stop_ok, output int stop_start);
    stop_start = 0;
    for (int i = 0; i < 10; i++) begin
      logic v;
      v = (i == 0) ? 1'b0 : (i == 9) ? stop_ok : b[i-1];
      @(negedge clk);
      drive_line(v);
      if (i == 9) stop_start = cyc;
      repeat (div - 1) @(negedge clk);
    end
    @(negedge clk);
    drive_line(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    int t0, ss;
    bit exp_trig;
    t0 = trig_total;
    send_raw(b, stop_ok, ss);
    repeat (4) @(negedge clk);
    exp_trig = stop_ok && m_match_en && (b == m_match);
    if (stop_ok) begin
      if (byte_q.size() < DEPTH) byte_q.push_back(b);
      else m_ovf = 1;
    end else begin
      m_ferr = 1;
    end
    chk($sformatf("trig_cnt(%02h)", b), trig_total - t0, exp_trig);
    if (exp_trig)
      chk("trig_window", (trig_last >= ss) && (trig_last <= ss + div + 2), 1);
  endtask

  task automatic check_state(input string tag);
    logic [7:0] d;
    int n;
    n = byte_q.size();
    rd(DAT, 16'd0, 0, d);
    chk({tag, ".count"}, d, (n > 255) ? 255 : n);
    rd(CFG, 16'd3, 0, d);
    chk({tag, ".status"}, d, {4'b0, m_ferr, m_ovf, (n == DEPTH), (n == 0)});
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] d, e;
    e = (byte_q.size() > 0) ? byte_q[0] : 8'h00;
    rd(DAT, 16'd1, 1, d);
    chk(tag, d, e);
    if (byte_q.size() > 0) void'(byte_q.pop_front());
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: cycle %0d reached, required finish earlier", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    int ss;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;

    // Reset state
    for (int b = 0; b < 5; b++) begin
      rd(CFG, 16'(b), 0, d);
      chk($sformatf("rst.cfg%0d", b), d, (b == 3) ? 1 : 0);
    end
    rd(DAT, 16'd0, 0, d); chk("rst.count", d, 0);
    rd(DAT, 16'd1, 0, d); chk("rst.head", d, 0);
    chk("rst.trig", trigger_o, 0);
    chk("rst.hyplen", reg_hyplen, 0);
    chk("stream", reg_stream, 0);

    // Length query
    @(negedge clk); reg_hypaddress = 6'd52; #1 chk("hyplen52", reg_hyplen, 5);
    @(negedge clk); reg_hypaddress = 6'd53; #1 chk("hyplen53", reg_hyplen, 2);
    @(negedge clk); reg_hypaddress = 6'd7;  #1 chk("hyplen7", reg_hyplen, 0);

    // Single byte receive and drain
    set_div(16);
    rd(CFG, 16'd0, 0, d); chk("div_lo", d, 16);
    set_ctrl(1, 0, 0, 0);
    send_frame(8'hA5, 1);
    check_state("a5");
    pop_check("a5.pop");
    check_state("a5.drained");
    pop_check("empty.pop");

    // Byte-match trigger
    set_match(8'h3C);
    set_ctrl(1, 0, 0, 1);
    rd(CFG, 16'd2, 0, d); chk("ctrl_rb", d, 8'h09);
    send_frame(8'h11, 1);
    send_frame(8'h3C, 1);
    pop_check("m.pop0");
    pop_check("m.pop1");

    // Overflow and flush
    set_ctrl(1, 0, 0, 0);
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1);
    check_state("ovf");
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      reg_address = 6'd7; reg_bytecnt = 16'(b); reg_addrvalid = 1'b1;
      #1 chk($sformatf("addr7.b%0d", b), reg_datao, 0);
    end
    @(negedge clk); reg_addrvalid = 1'b0;
    for (int i = 0; i < 16; i++) pop_check($sformatf("ovf.pop%0d", i));
    check_state("ovf.drained");
    set_ctrl(1, 0, 1, 0);
    rd(CFG, 16'd2, 0, d); chk("flush_rb", d, 8'h01);
    check_state("flushed");

    // Framing error: no push, no trigger
    set_match(8'h55);
    set_ctrl(1, 0, 0, 1);
    send_frame(8'h55, 0);
    check_state("ferr");
    set_ctrl(1, 0, 1, 0);
    check_state("ferr.flushed");

    // Glitch on io2, then disable mid-frame
    set_ctrl(1, 1, 0, 0);
    @(negedge clk); rx_io2 = 1'b0;
    repeat (3) @(negedge clk); rx_io2 = 1'b1;
    repeat (24) @(negedge clk);
    check_state("glitch");
    fork
      send_raw(8'hFF, 1, ss);
      begin
        repeat (40) @(negedge clk);
        set_ctrl(0, 1, 0, 0);
      end
    join
    repeat (4) @(negedge clk);
    check_state("disabled");
    set_ctrl(1, 1, 0, 0);
    send_frame(8'h5A, 1);
    check_state("after_dis");
    pop_check("after_dis.pop");

    // Randomized frames, pops and status reads
    set_div($urandom_range(10, 24));
    set_match(8'($urandom));
    set_ctrl(1, 1'($urandom_range(0, 1)), 0, 1);
    for (int k = 0; k < 40; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        logic [7:0] b;
        b = ($urandom_range(0, 3) == 0) ? m_match : 8'($urandom);
        send_frame(b, $urandom_range(0, 9) != 0);
      end else if (r < 9) begin
        pop_check($sformatf("rnd.pop%0d", k));
      end else begin
        check_state($sformatf("rnd%0d", k));
      end
    end
    check_state("rnd.end");

    // Mid-operation reset
    send_frame(8'h77, 1);
    @(negedge clk); reset_i = 1'b1;
    @(negedge clk); reset_i = 1'b0;
    byte_q.delete(); m_ovf = 0; m_ferr = 0; m_match_en = 0; m_match = 8'h00; m_src = 0;
    rd(CFG, 16'd0, 0, d); chk("mrst.div", d, 0);
    rd(CFG, 16'd2, 0, d); chk("mrst.ctrl", d, 0);
    rd(CFG, 16'd4, 0, d); chk("mrst.match", d, 0);
    check_state("mrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_serialsniff.md
Name: reg_serialsniff

Overview:
- Register-bus peripheral that passively sniffs the target UART (target_io1 or target_io2).
- Decodes 8N1 frames into a small FIFO that the host drains over the register bus.
- Emits a one-cycle trigger when a programmable byte is received; intended to feed a trigger-mux input such as trigger_advio_i.
- Sits beside the other reg_* blocks on the register bus. Its reg_datao and reg_hyplen are OR-combined onto the bus, so both must be zero when the block is not addressed.

Parameters:
- CFG_ADDR, 6'd52: configuration/status register address.
- DATA_ADDR, 6'd53: FIFO read register address.
- FIFO_DEPTH, 16: receive FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock (clk_usb_buf domain).
- reset_i  in  1  synchronous, active-high reset.
- reg_address  in  6  register address.
- reg_bytecnt  in  16  byte index within the register.
- reg_datai  in  8  write data from the bus.
- reg_datao  out  8  read data; 0 when not addressed.
- reg_size  in  16  transfer size; unused.
- reg_read  in  1  read strobe, one cycle per byte.
- reg_write  in  1  write strobe, one cycle per byte.
- reg_addrvalid  in  1  address qualifier.
- reg_hypaddress  in  6  length-query address.
- reg_hyplen  out  16  register length; 0 when not matched.
- reg_stream  out  1  tied 0.
- rx_io1  in  1  target_io1 (sniff only, never driven).
- rx_io2  in  1  target_io2 (sniff only, never driven).
- trigger_o  out  1  match pulse.

Behaviour:
- Reset values: reg_datao=0, reg_hyplen=0, trigger_o=0, divisor=16'd0, enable=0, match_en=0, match=8'h00, FIFO empty, overflow=0, ferr=0, RX FSM in IDLE.
- reg_hyplen is combinational: 5 when reg_hypaddress==CFG_ADDR, 2 when ==DATA_ADDR, else 0.
- CFG_ADDR byte map:
  - b0: divisor[7:0], R/W.
  - b1: divisor[15:8], R/W.
  - b2: bit0 enable, bit1 src (0=io1, 1=io2), bit2 flush (write-1 self-clearing, reads 0), bit3 match_en; R/W.
  - b3: status, read-only; writes ignored. bit0 empty, bit1 full, bit2 overflow (sticky), bit3 ferr (sticky framing error).
  - b4: match byte, R/W.
- A register write takes effect on the cycle after reg_write && reg_addrvalid && address match.
- DATA_ADDR byte map:
  - b0: occupancy count, 0..FIFO_DEPTH (saturates at 255).
  - b1: FIFO head byte; 0 if empty.
- Pop rule: the FIFO pops on reg_read && reg_addrvalid && reg_address==DATA_ADDR && reg_bytecnt==1 && !empty. Reading b1 while empty returns 0 and does not pop.
- reg_datao is combinational from the current address/bytecnt and is 0 otherwise.
- Input path: the selected line passes through a 2-flop synchronizer; the idle level is 1.
- RX FSM, counter cnt (16-bit), bit index (3-bit):
  - IDLE: on synchronized falling edge with enable=1 and divisor>=4 → START, cnt=divisor>>1.
  - START: at cnt==0, sample. If the line is 0 → DATA, cnt=divisor-1. If the line is 1 (glitch) → IDLE.
  - DATA: sample at each cnt==0, LSB first, reload cnt; after 8 bits → STOP.
  - STOP: sample at cnt==0. Line 1 → push byte. Line 0 → drop byte, set ferr. Either way → IDLE; a new start edge may be accepted the next cycle.
- enable deasserting, or divisor<4, mid-frame forces IDLE and discards the partial byte.
- Trigger: trigger_o is high for exactly one cycle, the cycle after a valid stop bit, when match_en=1 and byte==match. This holds even if the FIFO is full and the byte is dropped.
- FIFO rules:
  - Push and pop in the same cycle is allowed, including when full; count is unchanged.
  - Push when full without a pop drops the byte and sets overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- Flush clears FIFO pointers, overflow and ferr in one cycle. A push coinciding with a flush is discarded.
- A mid-operation reset_i returns everything to the reset values on the next edge.

Decomposition:
- Package serialsniff_pkg holds:
  - RX state enum (IDLE, START, DATA, STOP).
  - Byte-offset constants for the CFG fields.
  - Status bit indices.
  - Hyplen constants 5 and 2.
- Sub-module uart_rx_core contains the synchronizer, FSM and counters. Its outputs are a data_valid pulse, data[7:0] and a frame_err pulse.
- reg_serialsniff itself holds the FIFO, register decode and match logic.

Test Plan:
- divisor=16, enable=1, src=0; send 0xA5 on rx_io1 → DATA b0 reads 1, b1 reads 0xA5, then b0 reads 0 and status.empty=1.
- match=0x3C, match_en=1; send 0x11 then 0x3C → trigger_o stays low for 0x11 and pulses exactly 1 cycle after the 0x3C stop-bit sample.
- Send 17 bytes 0x00..0x10 with FIFO_DEPTH=16 → count=16, overflow=1, pops return 0x00..0x0F; write flush → count=0, overflow=0.
- Send 0x55 with stop bit held 0 → no push, ferr=1, trigger_o does not fire even if match=0x55.
- Pulse rx_io2 low for 3 cycles with src=1, divisor=16 → returns to IDLE, no push; then clear enable mid-frame of 0xFF → no push, and a following frame with enable=1 is received correctly.
- hypaddress=52 → reg_hyplen=5; 53 → 2; 7 → 0. With reg_address=7, reg_datao stays 0 throughout.
